frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer.sv | 130 +++++++++++++
 tb/tb_frame_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Frame sequencer: clears the back buffer, hands triangles one at a time to the
// rasterizer and swaps front/back buffers on the vsync falling edge after a frame end.
`timescale 1ns/1ps
module frame_sequencer #(
    parameter int unsigned CLEAR_WORDS = 76800,
    parameter int unsigned ADDR_W      = 17,
    parameter logic [15:0] Z_FAR       = 16'hFFFF
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [191:0]      fifo_dout,
    output logic [191:0]      tri_data,
    output logic              tri_valid,
    input  logic              tri_ready,
    input  logic              raster_done,
    input  logic              frame_end_req,
    input  logic              vsync,
    input  logic [7:0]        clear_color,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic [7:0]        clr_color,
    output logic [15:0]       clr_z,
    output logic              back_sel,
    output logic              frame_pending,
    output logic [15:0]       frame_count,
    output logic [2:0]        controller_state
);

    typedef enum logic [2:0] {
        CLEAR    = 3'd0,
        WAIT_TRI = 3'd1,
        FETCH    = 3'd2,
        ISSUE    = 3'd3,
        RASTER   = 3'd4,
        WAIT_VS  = 3'd5
    } state_t;

    localparam logic [ADDR_W:0] CLEAR_END = (ADDR_W+1)'(CLEAR_WORDS);

    state_t          state;
    logic [ADDR_W:0] clr_cnt;
    logic            vsync_q;
    logic            vsync_fall;

    assign vsync_fall       = vsync_q & ~vsync;
    assign controller_state = state;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state         <= CLEAR;
            clr_cnt       <= '0;
            vsync_q       <= 1'b0;
            fifo_rd_en    <= 1'b0;
            tri_data      <= '0;
            tri_valid     <= 1'b0;
            clr_we        <= 1'b0;
            clr_addr      <= '0;
            clr_color     <= '0;
            clr_z         <= '0;
            back_sel      <= 1'b0;
            frame_pending <= 1'b0;
            frame_count   <= '0;
        end else begin
            fifo_rd_en <= 1'b0;
            clr_we     <= 1'b0;
            clr_color  <= '0;
            clr_z      <= '0;
            vsync_q    <= vsync;
            if (frame_end_req) begin
                frame_pending <= 1'b1;
            end

            case (state)
                // The counter runs one past the last address so the idle cycle
                // after the final write is where the state leaves CLEAR.
                CLEAR: begin
                    if (clr_cnt == CLEAR_END) begin
                        clr_cnt <= '0;
                        state   <= WAIT_TRI;
                    end else begin
                        clr_we    <= 1'b1;
                        clr_addr  <= clr_cnt[ADDR_W-1:0];
                        clr_color <= clear_color;
                        clr_z     <= Z_FAR;
                        clr_cnt   <= clr_cnt + 1'b1;
                    end
                end
                WAIT_TRI: begin
                    if (!fifo_empty) begin
                        fifo_rd_en <= 1'b1;
                        state      <= FETCH;
                    end else if (frame_pending) begin
                        state <= WAIT_VS;
                    end
                end
                // First FETCH cycle is the pop itself; fifo_dout is valid on the second.
                FETCH: begin
                    if (!fifo_rd_en) begin
                        tri_data  <= fifo_dout;
                        tri_valid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (tri_ready) begin
                        tri_valid <= 1'b0;
                        state     <= RASTER;
                    end
                end
                RASTER: begin
                    if (raster_done) begin
                        state <= WAIT_TRI;
                    end
                end
                WAIT_VS: begin
                    if (vsync_fall) begin
                        back_sel      <= ~back_sel;
                        frame_pending <= frame_end_req;
                        frame_count   <= frame_count + 16'd1;
                        state         <= CLEAR;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomized bench for frame_sequencer: FIFO and rasterizer models plus a triangle
// scoreboard run alongside directed frame-submit, vsync and reset scenarios.
`timescale 1ns/1ps
module tb_frame_sequencer;

    localparam int CLEAR_WORDS = 16;
    localparam int ADDR_W      = 4;
    localparam logic [2:0] S_CLEAR = 3'd0, S_WAIT_TRI = 3'd1, S_RASTER = 3'd4, S_WAIT_VS = 3'd5;

    logic              axi_aclk      = 1'b0;
    logic              axi_aresetn   = 1'b0;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [191:0]      fifo_dout     = '0;
    logic [191:0]      tri_data;
    logic              tri_valid;
    logic              tri_ready     = 1'b0;
    logic              raster_done   = 1'b0;
    logic              frame_end_req = 1'b0;
    logic              vsync         = 1'b0;
    logic [7:0]        clear_color   = 8'h5A;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic [7:0]        clr_color;
    logic [15:0]       clr_z;
    logic              back_sel;
    logic              frame_pending;
    logic [15:0]       frame_count;
    logic [2:0]        controller_state;

    int tests_run = 0, tests_failed = 0;
    int cyc = 0, pop_cyc = 0, pops = 0, pushed = 0, accepted = 0;
    int err_rd_empty = 0, err_rd_long = 0, err_outstanding = 0, err_overlap = 0;
    int clr_writes = 0, clr_errs = 0, clr_next = 0;
    bit rd_prev = 0, valid_prev = 0;
    bit ready_random = 0, done_random = 0, spurious_en = 0;
    int done_delay = 5;

    logic [191:0] fifo_mem [0:255];
    logic [7:0]   wr_ptr = '0, rd_ptr = '0;
    logic [191:0] exp_q [$];

    frame_sequencer #(.CLEAR_WORDS(CLEAR_WORDS), .ADDR_W(ADDR_W), .Z_FAR(16'hFFFF)) dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .tri_data(tri_data), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .raster_done(raster_done), .frame_end_req(frame_end_req), .vsync(vsync),
        .clear_color(clear_color), .clr_we(clr_we), .clr_addr(clr_addr),
        .clr_color(clr_color), .clr_z(clr_z), .back_sel(back_sel),
        .frame_pending(frame_pending), .frame_count(frame_count),
        .controller_state(controller_state)
    );

    always #5 axi_aclk = ~axi_aclk;

    // Triangle FIFO with first-word latency of one cycle after the pop strobe.
    assign fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge axi_aclk) begin
        if (fifo_rd_en) begin
            fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    task automatic checkOutput(input string tag, input logic [191:0] actual, input logic [191:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [191:0] randTri();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic applyStimulus(input logic [191:0] tri_word);
        fifo_mem[wr_ptr] = tri_word;
        wr_ptr = wr_ptr + 8'd1;
        exp_q.push_back(tri_word);
        pushed++;
    endtask

    task automatic waitState(input logic [2:0] target, input int budget, input string tag);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge axi_aclk); #1;
            if (controller_state == target) seen = 1;
        end
        checkOutput(tag, 192'(seen), 192'(1));
    endtask

    task automatic waitAccepted(input int target, input int budget, input string tag);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge axi_aclk); #1;
            if (accepted >= target) seen = 1;
        end
        checkOutput(tag, 192'(seen), 192'(1));
    endtask

    // Expects the next clock edge to issue the first of CLEAR_WORDS writes.
    task automatic checkClear(input string tag);
        clr_writes = 0;
        @(posedge axi_aclk); #1;
        checkOutput({tag, "_first_we"}, 192'(clr_we), 192'(1));
        checkOutput({tag, "_first_addr"}, 192'(clr_addr), 192'(0));
        repeat (CLEAR_WORDS) @(posedge axi_aclk);
        #1;
        checkOutput({tag, "_we_off"}, 192'(clr_we), 192'(0));
        checkOutput({tag, "_state"}, 192'(controller_state), 192'(S_WAIT_TRI));
        checkOutput({tag, "_writes"}, 192'(clr_writes), 192'(CLEAR_WORDS));
    endtask

    task automatic pulseFrameEnd();
        @(negedge axi_aclk); frame_end_req = 1'b1;
        @(negedge axi_aclk); frame_end_req = 1'b0;
    endtask

    // Ends #1 after the clock edge that sees the falling vsync.
    task automatic vsyncFall(input bit with_req);
        @(negedge axi_aclk); vsync = 1'b1;
        repeat (2) @(negedge axi_aclk);
        vsync = 1'b0;
        frame_end_req = with_req;
        @(posedge axi_aclk); #1;
    endtask

    // Observes invariants first, then plays the rasterizer for the coming cycle.
    initial begin : rasterizer_model
        int done_cnt;
        bit busy;
        logic [191:0] want;
        done_cnt = 0;
        busy = 0;
        forever begin
            @(negedge axi_aclk);
            cyc++;
            if (fifo_rd_en) begin
                pops++;
                pop_cyc = cyc;
                if (fifo_empty) err_rd_empty++;
                if (rd_prev) err_rd_long++;
                if (tri_valid || busy) err_outstanding++;
            end
            if (tri_valid && controller_state == S_RASTER) err_overlap++;
            if (tri_valid && !valid_prev) checkOutput("pop_to_valid", 192'(cyc - pop_cyc), 192'(2));
            rd_prev = fifo_rd_en;
            valid_prev = tri_valid;
            if (clr_we) begin
                clr_writes++;
                if (clr_addr != ADDR_W'(clr_next) || clr_z != 16'hFFFF || clr_color != clear_color) clr_errs++;
                clr_next++;
            end else begin
                clr_next = 0;
            end

            raster_done = 1'b0;
            if (!axi_aresetn) begin
                busy = 0;
                tri_ready = 1'b0;
            end else begin
                if (busy) begin
                    done_cnt--;
                    if (done_cnt == 0) begin
                        raster_done = 1'b1;
                        busy = 0;
                    end
                end else if (spurious_en && $urandom_range(0, 7) == 0) begin
                    raster_done = 1'b1;
                end
                tri_ready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
                if (tri_valid && tri_ready && !busy) begin
                    accepted++;
                    if (exp_q.size() == 0) begin
                        checkOutput("tri_unexpected", 192'(1), 192'(0));
                    end else begin
                        want = exp_q.pop_front();
                        checkOutput("tri_data", tri_data, want);
                    end
                    busy = 1;
                    done_cnt = done_random ? int'($urandom_range(1, 8)) : done_delay;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc0;
        repeat (3) @(negedge axi_aclk);
        checkOutput("reset_state", 192'(controller_state), 192'(S_CLEAR));
        checkOutput("reset_strobes", 192'({clr_we, fifo_rd_en, tri_valid}), 192'(0));
        checkOutput("reset_frame", 192'({back_sel, frame_pending, frame_count}), 192'(0));
        checkOutput("reset_tri_data", tri_data, 192'(0));
        checkOutput("reset_clr_port", 192'({clr_addr, clr_color, clr_z}), 192'(0));

        @(negedge axi_aclk); axi_aresetn = 1'b1;
        checkClear("clear0");

        // Three triangles, ready tied high, done five cycles after accept.
        for (int i = 0; i < 3; i++) begin
            @(negedge axi_aclk);
            applyStimulus(randTri());
        end
        waitAccepted(3, 200, "three_accepted");
        waitState(S_WAIT_TRI, 50, "three_done");
        checkOutput("three_pops", 192'(pops), 192'(3));
        checkOutput("three_drained", 192'(exp_q.size()), 192'(0));

        // Frame end with two triangles still queued.
        ready_random = 1; done_random = 1; spurious_en = 1;
        acc0 = accepted;
        @(negedge axi_aclk);
        applyStimulus(randTri());
        applyStimulus(randTri());
        frame_end_req = 1'b1;
        @(negedge axi_aclk); frame_end_req = 1'b0;
        checkOutput("pending_set", 192'(frame_pending), 192'(1));
        waitState(S_WAIT_VS, 500, "reach_wait_vs");
        checkOutput("drawn_before_vs", 192'(accepted - acc0), 192'(2));
        vsyncFall(0);
        checkOutput("swap1_back_sel", 192'(back_sel), 192'(1));
        checkOutput("swap1_count", 192'(frame_count), 192'(1));
        checkOutput("swap1_pending", 192'(frame_pending), 192'(0));
        checkOutput("swap1_state", 192'(controller_state), 192'(S_CLEAR));
        checkClear("clear1");

        // Two frame ends before the swap, vsync already low on entry.
        clear_color = 8'($urandom());
        pulseFrameEnd();
        repeat (2) @(negedge axi_aclk);
        pulseFrameEnd();
        waitState(S_WAIT_VS, 50, "reach_wait_vs2");
        repeat (20) @(negedge axi_aclk);
        checkOutput("low_vsync_no_swap", 192'({controller_state, frame_count}), 192'({S_WAIT_VS, 16'd1}));
        vsyncFall(0);
        checkOutput("swap2_count", 192'(frame_count), 192'(2));
        checkOutput("swap2_back_sel", 192'(back_sel), 192'(0));
        checkOutput("swap2_pending", 192'(frame_pending), 192'(0));
        checkClear("clear2");
        repeat (10) @(negedge axi_aclk);
        checkOutput("single_swap", 192'({controller_state, frame_count, frame_pending}),
                    192'({S_WAIT_TRI, 16'd2, 1'b0}));

        // Frame end coinciding with the swap stays pending.
        pulseFrameEnd();
        waitState(S_WAIT_VS, 50, "reach_wait_vs3");
        vsyncFall(1);
        checkOutput("swap3_count", 192'(frame_count), 192'(3));
        checkOutput("swap3_back_sel", 192'(back_sel), 192'(1));
        checkOutput("swap3_pending_kept", 192'(frame_pending), 192'(1));
        @(negedge axi_aclk); frame_end_req = 1'b0;

        // A queued triangle wins over the pending frame end; reset it mid-raster.
        spurious_en = 0; ready_random = 0; done_random = 0; done_delay = 40;
        applyStimulus(randTri());
        waitState(S_RASTER, 100, "fifo_priority");
        checkOutput("pending_while_raster", 192'(frame_pending), 192'(1));
        @(negedge axi_aclk); #2;
        axi_aresetn = 1'b0;
        #1;
        checkOutput("abort_strobes", 192'({tri_valid, fifo_rd_en, clr_we}), 192'(0));
        checkOutput("abort_frame", 192'({back_sel, frame_pending, frame_count}), 192'(0));
        checkOutput("abort_state", 192'(controller_state), 192'(S_CLEAR));
        checkOutput("abort_tri_data", tri_data, 192'(0));
        repeat (3) @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        checkClear("clear_after_reset");

        // Random burst of triangles with random handshake timing.
        ready_random = 1; done_random = 1; spurious_en = 1;
        acc0 = accepted;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 6)) @(negedge axi_aclk);
            @(negedge axi_aclk);
            applyStimulus(randTri());
        end
        waitAccepted(acc0 + 8, 1000, "burst_accepted");
        waitState(S_WAIT_TRI, 50, "burst_done");
        checkOutput("burst_drained", 192'(exp_q.size()), 192'(0));
        clear_color = 8'($urandom());
        pulseFrameEnd();
        waitState(S_WAIT_VS, 50, "reach_wait_vs4");
        vsyncFall(0);
        checkOutput("swap4_frame", 192'({back_sel, frame_pending, frame_count}), 192'({1'b1, 1'b0, 16'd1}));
        checkClear("clear4");

        checkOutput("pops_total", 192'(pops), 192'(pushed));
        checkOutput("accepts_total", 192'(accepted), 192'(pushed));
        checkOutput("rd_en_while_empty", 192'(err_rd_empty), 192'(0));
        checkOutput("rd_en_multi_cycle", 192'(err_rd_long), 192'(0));
        checkOutput("outstanding", 192'(err_outstanding), 192'(0));
        checkOutput("valid_in_raster", 192'(err_overlap), 192'(0));
        checkOutput("clear_words", 192'(clr_errs), 192'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
